// File: rtl/tft_pkg.sv
// Shared TFT display constants and the fetch-FSM state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package tft_pkg;

    // Active area, also used by the TFT timing generator
    localparam int H_ACTIVE   = 800;
    localparam int V_ACTIVE   = 480;

    // Pixel FIFO capacity and default burst size, in 16-bit words
    localparam int FIFO_DEPTH = 1024;
    localparam int BURST_LEN  = 64;

    // Fetch FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_FILL  = 3'd2;
    localparam logic [2:0] ST_REQ   = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_CLEAR = ST_CLEAR,
        S_FILL  = ST_FILL,
        S_REQ   = ST_REQ,
        S_WAIT  = ST_WAIT,
        S_DONE  = ST_DONE
    } fetch_state_t;

endpackage

// File: rtl/tft_frame_fetch_ctrl.sv
// Frame-buffer read scheduler: clears the pixel FIFO per frame, then issues bursts to keep it topped up.
// Latency: 2 clear cycles, one space-check cycle, then rd_req; freed FIFO space -> rd_req next cycle.
// Backpressure: rd_req held until rd_ack; one burst outstanding; no request unless the whole burst fits.
module tft_frame_fetch_ctrl
    import tft_pkg::*;
#(
    parameter int              H_ACTIVE   = tft_pkg::H_ACTIVE,
    parameter int              V_ACTIVE   = tft_pkg::V_ACTIVE,
    parameter int              BURST_LEN  = tft_pkg::BURST_LEN,
    parameter int              FIFO_DEPTH = tft_pkg::FIFO_DEPTH,
    parameter int              ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              Clk33M,
    input  logic              Rst_n,
    input  logic              en,
    input  logic              frame_start,
    input  logic [10:0]       fifo_usedw,
    input  logic              fifo_empty,
    input  logic              pix_rd,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [6:0]        rd_len,
    input  logic              rd_ack,
    input  logic              rd_done,
    output logic              fifo_clr,
    output logic              busy,
    output logic              frame_late,
    output logic              underflow
);

    localparam logic [18:0] TOTAL_WORDS = 19'(H_ACTIVE * V_ACTIVE);

    fetch_state_t state, state_nxt;
    logic         clr_cnt;        // 0 on the first clear cycle, 1 on the second
    logic [18:0]  words_left;
    logic         resync_pending; // frame_start seen while a handshake was in flight
    logic         clear_load;     // entering (or restarting) CLEAR this cycle
    logic [6:0]   len_nxt;
    logic         space_ok;
    logic [18:0]  len_sub;

    // Next burst size and whether the whole burst fits in the FIFO (12-bit compare, no overflow)
    always_comb begin
        len_nxt  = (words_left < 19'(BURST_LEN)) ? words_left[6:0] : 7'(BURST_LEN);
        space_ok = ({1'b0, fifo_usedw} + {5'b0, len_nxt}) <= 12'(FIFO_DEPTH);
        len_sub  = (19'(rd_len) > words_left) ? words_left : 19'(rd_len);
    end

    // Fetch FSM state register
    always_ff @(posedge Clk33M or negedge Rst_n) begin
        if (!Rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Fetch FSM next-state logic; clear_load marks every entry into CLEAR
    always_comb begin
        state_nxt  = state;
        clear_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start && en) begin
                    state_nxt  = S_CLEAR;
                    clear_load = 1'b1;
                end
            end
            S_CLEAR: begin
                if (frame_start) begin
                    state_nxt  = S_CLEAR;
                    clear_load = 1'b1;
                end else if (clr_cnt) begin
                    state_nxt  = S_FILL;
                end
            end
            S_FILL: begin
                if (frame_start) begin
                    state_nxt  = S_CLEAR;
                    clear_load = 1'b1;
                end else if (!en) begin
                    state_nxt  = S_IDLE;
                end else if (words_left == '0) begin
                    state_nxt  = S_DONE;
                end else if (space_ok) begin
                    state_nxt  = S_REQ;
                end
            end
            // A request is never withdrawn: en and frame_start cannot leave REQ
            S_REQ: begin
                if (rd_ack) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (rd_done) begin
                    if (resync_pending || frame_start) begin
                        state_nxt  = S_CLEAR;
                        clear_load = 1'b1;
                    end else begin
                        state_nxt  = S_FILL;
                    end
                end
            end
            S_DONE: begin
                if (frame_start && en) begin
                    state_nxt  = S_CLEAR;
                    clear_load = 1'b1;
                end else if (!en) begin
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address, remaining-word count, burst length and clear-cycle counter
    always_ff @(posedge Clk33M or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_addr        <= BASE_ADDR;
            rd_len         <= '0;
            words_left     <= '0;
            clr_cnt        <= 1'b0;
            resync_pending <= 1'b0;
        end else if (clear_load) begin
            rd_addr        <= BASE_ADDR;
            words_left     <= TOTAL_WORDS;
            clr_cnt        <= 1'b0;
            resync_pending <= 1'b0;
        end else begin
            if (state == S_CLEAR) clr_cnt <= 1'b1;
            if (state == S_FILL && state_nxt == S_REQ) rd_len <= len_nxt;
            if ((state == S_REQ || state == S_WAIT) && frame_start) resync_pending <= 1'b1;
            if (state == S_WAIT && rd_done) begin
                rd_addr    <= rd_addr + ADDR_W'(rd_len);
                words_left <= words_left - len_sub;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge Clk33M or negedge Rst_n) begin
        if (!Rst_n) begin
            frame_late <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (frame_start && busy)  frame_late <= 1'b1;
            if (pix_rd && fifo_empty) underflow  <= 1'b1;
        end
    end

    // Outputs decoded from the state register
    always_comb begin
        rd_req   = (state == S_REQ);
        fifo_clr = (state == S_CLEAR);
        busy     = (state == S_CLEAR) || (state == S_FILL) ||
                   (state == S_REQ)   || (state == S_WAIT);
    end

endmodule

// File: tb/tb_tft_frame_fetch_ctrl.sv
// Bench for tft_frame_fetch_ctrl on a 10x10 frame (100 words: bursts of 64 then 36).
// Latency: n/a.
// Backpressure: bench plays the arbiter, acking and completing bursts with chosen delays.
module tb_tft_frame_fetch_ctrl;

    typedef struct {
        logic [23:0] addr;
        logic [6:0]  len;
    } burst_t;

    typedef struct {
        logic [10:0] usedw;
        logic        exp_req;
    } vec_t;

    logic        Clk33M = 1'b0;
    logic        Rst_n;
    logic        en;
    logic        frame_start;
    logic [10:0] fifo_usedw;
    logic        fifo_empty;
    logic        pix_rd;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic [6:0]  rd_len;
    logic        rd_ack;
    logic        rd_done;
    logic        fifo_clr;
    logic        busy;
    logic        frame_late;
    logic        underflow;

    int     checks = 0;
    int     errors = 0;
    burst_t exp_q[$];
    vec_t   vecs[7];

    always #5 Clk33M = ~Clk33M;

    tft_frame_fetch_ctrl #(
        .H_ACTIVE(10), .V_ACTIVE(10), .BURST_LEN(64), .FIFO_DEPTH(1024),
        .ADDR_W(24), .BASE_ADDR(24'd0)
    ) dut (
        .Clk33M(Clk33M), .Rst_n(Rst_n), .en(en), .frame_start(frame_start),
        .fifo_usedw(fifo_usedw), .fifo_empty(fifo_empty), .pix_rd(pix_rd),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
        .rd_done(rd_done), .fifo_clr(fifo_clr), .busy(busy),
        .frame_late(frame_late), .underflow(underflow)
    );

    task automatic tick();
        @(negedge Clk33M);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rd_req"},     32'(rd_req),     32'd0);
        chk({tag, "_rd_addr"},    32'(rd_addr),    32'd0);
        chk({tag, "_rd_len"},     32'(rd_len),     32'd0);
        chk({tag, "_fifo_clr"},   32'(fifo_clr),   32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_frame_late"}, 32'(frame_late), 32'd0);
        chk({tag, "_underflow"},  32'(underflow),  32'd0);
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Bounded wait for rd_req; returns on the negedge where it is seen
    task automatic wait_req(input string tag);
        int n = 0;
        while (!rd_req && n < 20) begin
            tick();
            n++;
        end
        if (!rd_req) chk({tag, "_wait_req_timeout"}, 32'd0, 32'd1);
    endtask

    // Pop the expected burst and compare the request fields against it
    task automatic pop_chk(input string tag, output burst_t b);
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_req"}, 32'd1, 32'd0);
            b = '{24'd0, 7'd0};
        end else begin
            b = exp_q.pop_front();
            chk({tag, "_rd_addr"}, 32'(rd_addr), 32'(b.addr));
            chk({tag, "_rd_len"},  32'(rd_len),  32'(b.len));
        end
    endtask

    // Arbiter: hold off ack, check request stays stable, ack, then rd_done after done_dly cycles
    task automatic do_burst(input string tag, input int ack_dly, input int done_dly,
                            input logic [10:0] park_usedw);
        burst_t b;
        pop_chk(tag, b);
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            chk({tag, "_req_held"},  32'(rd_req),  32'd1);
            chk({tag, "_addr_held"}, 32'(rd_addr), 32'(b.addr));
        end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        chk({tag, "_req_drop"}, 32'(rd_req), 32'd0);
        for (int i = 1; i < done_dly; i++) tick();
        fifo_usedw = park_usedw;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int clr_cycles;
        int first_req;
        int req_in_clr;

        vecs[0] = '{11'd1000, 1'b0};
        vecs[1] = '{11'd961,  1'b0};
        vecs[2] = '{11'd2047, 1'b0};
        vecs[3] = '{11'd1024, 1'b0};
        vecs[4] = '{11'd960,  1'b1};  // 960+64 == 1024 fits exactly
        vecs[5] = '{11'd989,  1'b0};  // second burst is 36 words
        vecs[6] = '{11'd988,  1'b1};

        Rst_n = 1'b0; en = 1'b0; frame_start = 1'b0; fifo_usedw = '0;
        fifo_empty = 1'b0; pix_rd = 1'b0; rd_ack = 1'b0; rd_done = 1'b0;
        repeat (3) tick();
        chk_reset("por");
        Rst_n = 1'b1;
        tick();

        // Basic frame: two clear cycles, then 64 @ 0 and 36 @ 64, then DONE
        en = 1'b1;
        fifo_usedw = 11'd0;
        exp_q.push_back('{24'd0, 7'd64});
        exp_q.push_back('{24'd64, 7'd36});
        pulse_frame_start();
        clr_cycles = 0; first_req = -1; req_in_clr = 0;
        for (int i = 0; i < 8; i++) begin
            if (rd_req) begin
                first_req = i;
                if (fifo_clr) req_in_clr = 1;
                break;
            end
            if (fifo_clr) clr_cycles++;
            tick();
        end
        chk("clr_cycles", 32'(clr_cycles), 32'd2);
        chk("req_during_clr", 32'(req_in_clr), 32'd0);
        chk("req_latency", 32'(first_req >= 2 && first_req <= 3), 32'd1);
        do_burst("b1", 3, 64, 11'd0);
        wait_req("b2");
        do_burst("b2", 2, 10, 11'd0);
        repeat (2) tick();
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_no_req", 32'(rd_req), 32'd0);
        chk("done_late", 32'(frame_late), 32'd0);

        // Space threshold table; frame_start from DONE is not late
        fifo_usedw = 11'd2000;
        exp_q.push_back('{24'd0, 7'd64});
        exp_q.push_back('{24'd64, 7'd36});
        pulse_frame_start();
        repeat (4) tick();
        chk("thr_idle_req", 32'(rd_req), 32'd0);
        chk("thr_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 7; i++) begin
            fifo_usedw = vecs[i].usedw;
            tick();
            chk($sformatf("thr_vec%0d_req", i), 32'(rd_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req && rd_req) do_burst($sformatf("thr_vec%0d", i), 1, 4, 11'd2000);
        end
        tick();
        chk("thr_done_busy", 32'(busy), 32'd0);
        chk("thr_late", 32'(frame_late), 32'd0);

        // Underflow is sticky
        chk("uf_before", 32'(underflow), 32'd0);
        fifo_empty = 1'b1; pix_rd = 1'b1;
        tick();
        fifo_empty = 1'b0; pix_rd = 1'b0;
        chk("uf_set", 32'(underflow), 32'd1);

        // frame_start during WAIT: burst completes, then clear and restart at base
        begin
            burst_t b;
            fifo_usedw = 11'd0;
            exp_q.push_back('{24'd0, 7'd64});
            pulse_frame_start();
            wait_req("rs");
            pop_chk("rs", b);
            rd_ack = 1'b1;
            tick();
            rd_ack = 1'b0;
            pulse_frame_start();
            chk("rs_late", 32'(frame_late), 32'd1);
            chk("rs_busy", 32'(busy), 32'd1);
            chk("rs_no_req", 32'(rd_req), 32'd0);
            chk("rs_no_clr_yet", 32'(fifo_clr), 32'd0);
            repeat (3) tick();
            rd_done = 1'b1;
            tick();
            rd_done = 1'b0;
            chk("rs_clr", 32'(fifo_clr), 32'd1);
            exp_q.push_back('{24'd0, 7'd64});
            exp_q.push_back('{24'd64, 7'd36});
            wait_req("rs1");
            do_burst("rs1", 0, 5, 11'd0);
            wait_req("rs2");
            do_burst("rs2", 0, 5, 11'd0);
            tick();
            chk("rs_done_busy", 32'(busy), 32'd0);
            chk("rs_uf_sticky", 32'(underflow), 32'd1);
            chk("rs_late_sticky", 32'(frame_late), 32'd1);
        end

        // en dropped mid-frame with no burst outstanding -> IDLE
        fifo_usedw = 11'd2000;
        pulse_frame_start();
        repeat (4) tick();
        chk("en_busy", 32'(busy), 32'd1);
        en = 1'b0;
        repeat (2) tick();
        chk("en_off_busy", 32'(busy), 32'd0);
        chk("en_off_req", 32'(rd_req), 32'd0);

        // Reset asserted mid-burst
        begin
            burst_t b;
            en = 1'b1;
            fifo_usedw = 11'd0;
            exp_q.push_back('{24'd0, 7'd64});
            pulse_frame_start();
            wait_req("mr");
            pop_chk("mr", b);
            rd_ack = 1'b1;
            tick();
            rd_ack = 1'b0;
            Rst_n = 1'b0;
            #1;
            chk_reset("midrst");
            repeat (2) tick();
            Rst_n = 1'b1;
            repeat (4) tick();
            chk("post_rst_req", 32'(rd_req), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
